// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment patterns are logical (1 = lit), ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Maps a logical "lit" bit onto the pin level for the chosen display type.
    function automatic logic apply_polarity(input logic lit, input logic active_low);
        return lit ^ active_low;
    endfunction

endpackage

// File: rtl/bcd_seg_encoder.sv
// Combinational BCD to 7-segment encoder. Codes above 9 produce a blank digit.
module bcd_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    // Lookup of the logical segment pattern for one digit.
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned double
// buffering, leading-zero suppression and one blank cycle per digit slot.
//
// Input handshake: load is a single-cycle pulse with no back-pressure; the
// bcd/dp_in values present in that cycle are always accepted. A later load in
// the same frame overwrites an earlier one, and only the value held at the
// frame wrap (or presented on the wrap cycle itself) is displayed.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lz_blank,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = DIGIT_W * NUM_DIGITS;
    localparam logic [PW-1:0] PCNT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          ACTIVE_LOW = (COMMON_ANODE != 0);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         pending_bcd;
    logic [NUM_DIGITS-1:0] pending_dp;
    logic                  pending_valid;
    logic [BW-1:0]         active_bcd;
    logic [NUM_DIGITS-1:0] active_dp;
    logic                  wrap_q;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [DIGIT_W-1:0]    digit_sel;
    logic                  dp_sel;
    logic                  lz_suppress;
    logic [6:0]            enc_seg;
    logic [6:0]            seg_lit;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_end   = (pcnt == PCNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    // Prescaler and digit index; wrap_q remembers that the current state is
    // the first slot of a fresh frame so frame_tick lines up with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt   <= '0;
            idx    <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= frame_wrap;
            if (slot_end) begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Double buffer: loads land in pending; active only changes at the wrap,
    // taking the live inputs directly when a load coincides with the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_bcd   <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            active_bcd    <= '0;
            active_dp     <= '0;
        end else if (frame_wrap) begin
            pending_valid <= 1'b0;
            if (load) begin
                active_bcd <= bcd;
                active_dp  <= dp_in;
            end else if (pending_valid) begin
                active_bcd <= pending_bcd;
                active_dp  <= pending_dp;
            end
        end else if (load) begin
            pending_bcd   <= bcd;
            pending_dp    <= dp_in;
            pending_valid <= 1'b1;
        end
    end

    // Leading-zero mask: a digit is suppressed when it and every more
    // significant digit are zero; digit 0 always stays visible.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run && (active_bcd[k*DIGIT_W +: DIGIT_W] == '0);
            lz_mask[k] = lz_blank && zero_run && (k != 0);
        end
    end

    // Select the digit, decimal point and suppression flag addressed by idx.
    always_comb begin
        digit_sel   = '0;
        dp_sel      = 1'b0;
        lz_suppress = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                digit_sel   = active_bcd[i*DIGIT_W +: DIGIT_W];
                dp_sel      = active_dp[i];
                lz_suppress = lz_mask[i];
            end
        end
    end

    bcd_seg_encoder u_enc (
        .digit (digit_sel),
        .seg   (enc_seg)
    );

    assign seg_lit = lz_suppress ? SEG_BLANK : enc_seg;

    // Pin-level next values; digit enables stay off while pcnt is 0.
    always_comb begin
        seg_next = '0;
        an_next  = '0;
        for (int b = 0; b < 7; b++) begin
            seg_next[b] = apply_polarity(seg_lit[b], ACTIVE_LOW);
        end
        dp_next = apply_polarity(dp_sel, ACTIVE_LOW);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_next[i] = apply_polarity((pcnt != '0) && (idx == IW'(i)), ACTIVE_LOW);
        end
    end

    // Output registers; reset drives every pin to its inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{ACTIVE_LOW}};
            dp         <= ACTIVE_LOW;
            an         <= {NUM_DIGITS{ACTIVE_LOW}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_tick <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4 clocks per slot).
// A common-cathode and a common-anode instance share all inputs; each lit
// slot is checked against a queue of hand-computed {an, seg, dp} entries.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S9 = 7'b1101111;
  localparam logic [6:0] SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_blank = 1'b0;

  logic [6:0]  seg, seg_ca;
  logic        dp, dp_ca;
  logic [3:0]  an, an_ca;
  logic        frame_tick, ft_ca;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .COMMON_ANODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd(bcd), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .COMMON_ANODE(1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd(bcd), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_ca), .dp(dp_ca), .an(an_ca), .frame_tick(ft_ca)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // scoreboard state
  logic [11:0] exp_q[$];
  logic [11:0] e;
  int          vectors = 0;
  int          fails = 0;
  logic [3:0]  prev_an = 4'h0;
  logic        end_req = 1'b0;
  logic        end_ack = 1'b0;

  // monitor: off-state during reset, one pop per lit slot, frame_tick timing
  always @(negedge clk) begin
    if (!rst_n || cyc == 0) begin
      vectors++;
      if ({an, seg, dp, frame_tick} !== {4'h0, 7'h00, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_cc t=%0t got an=%b seg=%b dp=%b ft=%b want 0000/0000000/0/0",
                 $time, an, seg, dp, frame_tick);
      end
      vectors++;
      if ({an_ca, seg_ca, dp_ca, ft_ca} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_ca t=%0t got an=%b seg=%b dp=%b ft=%b want 1111/1111111/1/0",
                 $time, an_ca, seg_ca, dp_ca, ft_ca);
      end
    end else begin
      if (!end_req && an != 4'h0 && prev_an == 4'h0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_slot cyc=%0d got an=%b seg=%b dp=%b want none", cyc, an, seg, dp);
        end else begin
          e = exp_q.pop_front();
          if ({an, seg, dp} !== e) begin
            fails++;
            $display("FAIL slot_cc cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                     cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
          end
          vectors++;
          if ({an_ca, seg_ca, dp_ca} !== ~e) begin
            fails++;
            $display("FAIL slot_ca cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                     cyc, an_ca, seg_ca, dp_ca, ~e[11:8], ~e[7:1], ~e[0]);
          end
        end
      end
      if (frame_tick || ft_ca || (cyc % FRAME == 1 && cyc > FRAME)) begin
        vectors++;
        if (frame_tick !== (cyc % FRAME == 1 && cyc > FRAME) ||
            ft_ca !== (cyc % FRAME == 1 && cyc > FRAME)) begin
          fails++;
          $display("FAIL frame_tick cyc=%0d got cc=%b ca=%b want %b", cyc, frame_tick, ft_ca,
                   (cyc % FRAME == 1 && cyc > FRAME));
        end
      end
    end
    if (end_req && !end_ack) begin
      vectors++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
      end
      end_ack <= 1'b1;
    end
    prev_an <= an;
  end

  // directed frame table: what each frame shows, and loads issued during it
  typedef struct {
    logic        lz;
    int          a_off;
    logic [15:0] a_bcd;
    logic [3:0]  a_dp;
    int          b_off;
    logic [15:0] b_bcd;
    logic [3:0]  b_dp;
    logic [27:0] segs;   // {d3, d2, d1, d0}
    logic [3:0]  dps;
  } row_t;

  row_t rows[8];

  // driver: push the frame's expected slots, then walk its 16 state offsets
  task automatic run_frame(input int r);
    logic [3:0] a;
    for (int d = 0; d < ND; d++) begin
      a = 4'b0001 << d;
      exp_q.push_back({a, rows[r].segs[d*7 +: 7], rows[r].dps[d]});
    end
    lz_blank = rows[r].lz;
    for (int o = 0; o < FRAME; o++) begin
      if (o == rows[r].a_off) begin
        load = 1'b1; bcd = rows[r].a_bcd; dp_in = rows[r].a_dp;
      end else if (o == rows[r].b_off) begin
        load = 1'b1; bcd = rows[r].b_bcd; dp_in = rows[r].b_dp;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
    end
  endtask

  initial begin
    // power-on zeros; load 1234
    rows[0] = '{1'b0, 3, 16'h1234, 4'b0000, -1, 16'h0, 4'h0, {S0, S0, S0, S0}, 4'b0000};
    // shows 1234; two loads mid-frame, the second must win
    rows[1] = '{1'b0, 5, 16'h1111, 4'b0000, 7, 16'h2222, 4'b0000, {S1, S2, S3, S4}, 4'b0000};
    // shows 2222; load on the wrap cycle
    rows[2] = '{1'b0, 15, 16'h0070, 4'b1000, -1, 16'h0, 4'h0, {S2, S2, S2, S2}, 4'b0000};
    // lz on: 0070 -> blank, blank, 7, 0 with dp on digit 3
    rows[3] = '{1'b1, 2, 16'h0000, 4'b1000, -1, 16'h0, 4'h0, {SB, SB, S7, S0}, 4'b1000};
    // lz on: 0000 -> only digit 0 shows
    rows[4] = '{1'b1, 9, 16'hFA95, 4'b0101, -1, 16'h0, 4'h0, {SB, SB, SB, S0}, 4'b1000};
    // non-BCD F and A blank, dp still follows
    rows[5] = '{1'b0, 15, 16'h0305, 4'b0000, -1, 16'h0, 4'h0, {SB, SB, S9, S5}, 4'b0101};
    // lz on: 0305 -> inner zero kept
    rows[6] = '{1'b1, 0, 16'h8888, 4'b1111, 14, 16'h0006, 4'b0000, {SB, S3, S0, S5}, 4'b0000};
    // post-reset frames: empty buffers
    rows[7] = '{1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, {S0, S0, S0, S0}, 4'b0000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int f = 0; f < 7; f++) run_frame(f);

    // frame showing 0006 with lz off; reset lands mid-slot of digit 1
    exp_q.push_back({4'b0001, S6, 1'b0});
    exp_q.push_back({4'b0010, S0, 1'b0});
    lz_blank = 1'b0;
    for (int o = 0; o < 7; o++) begin
      if (o == 3) begin
        load = 1'b1; bcd = 16'h9999; dp_in = 4'hF;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
    end
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // scan restarts at digit 0 and the discarded 9999 never appears
    run_frame(7);
    run_frame(7);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL end_handshake got no ack want ack");
      $fatal(1, "monitor did not respond");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
